// File: rtl/axis_pack_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_pack_pkg
// Purpose  : Shared helpers for the AXI-Stream element packer.
//            lanes()    - number of input elements carried by one output word
//            keep_for() - TKEEP pattern for a word whose highest filled lane
//                         is lane_idx
// Revision : 1.0 - initial release
// ============================================================================
package axis_pack_pkg;

  // Widest TKEEP the helper can build (512-bit output word).
  localparam int unsigned KEEP_MAX = 64;

  // Packing mode gives OUT/IN lanes; zero-extend mode always has one lane.
  function automatic int unsigned lanes(input int unsigned pack,
                                        input int unsigned in_w,
                                        input int unsigned out_w);
    return (pack != 0) ? (out_w / in_w) : 1;
  endfunction

  // In packing mode only the bytes of lanes 0..lane_idx are valid.
  // In zero-extend mode the zero padding is still reported as valid bytes,
  // so every byte of the word is kept.
  function automatic logic [KEEP_MAX-1:0] keep_for(input int unsigned lane_idx,
                                                   input int unsigned in_bytes,
                                                   input int unsigned pack,
                                                   input int unsigned keep_w);
    logic [KEEP_MAX-1:0] k;
    k = '0;
    for (int unsigned b = 0; b < KEEP_MAX; b++) begin
      if (b < keep_w) begin
        if (pack != 0) k[b] = (b < (lane_idx + 1) * in_bytes);
        else           k[b] = 1'b1;
      end
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_sync_fifo
// Purpose  : Generic single-clock FIFO, DEPTH x WIDTH, first-word-fall-through
//            read port (rdata_o always shows the head entry).
// Ports    : clk, rst      - clock, synchronous active-high reset
//            push_i/wdata_i - write request and data (ignored when full)
//            pop_i          - read request (ignored when empty)
//            rdata_o        - head entry, don't-care when empty
//            full_o/empty_o - status
//            level_o        - occupied entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module axis_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q,  level_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              w_push, w_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i  & ~empty_o;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + LVL_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + LVL_W'(1);
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left without reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/axis_pack_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_pack_fifo
// Purpose  : Packs narrow model elements into wide DMA words (or zero-extends
//            one element per word), marks the last word of each frame with
//            TLAST, builds TKEEP for short final words and buffers completed
//            words in a FIFO ahead of the DMA S2MM channel.
// Ports    : clk, rst                      - clock, sync active-high reset
//            s_axis_tvalid/tdata/tready    - model element stream (slave)
//            m_axis_tvalid/tdata/tkeep/
//            tlast/tready                  - packed word stream (master)
//            level                         - occupied FIFO entries
// Revision : 1.0 - initial release
// ============================================================================
module axis_pack_fifo import axis_pack_pkg::*; #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned IN_DATA_WIDTH  = 8,
  parameter int unsigned OUT_DATA_WIDTH = 32,
  parameter int unsigned PACK           = 1,
  parameter int unsigned FRAME_ELEMS    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  input  logic [IN_DATA_WIDTH-1:0]      s_axis_tdata,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [OUT_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [OUT_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int unsigned LANES    = lanes(PACK, IN_DATA_WIDTH, OUT_DATA_WIDTH);
  localparam int unsigned KEEP_W   = OUT_DATA_WIDTH / 8;
  localparam int unsigned IN_BYTES = IN_DATA_WIDTH / 8;
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ELEM_W   = (FRAME_ELEMS > 1) ? $clog2(FRAME_ELEMS) : 1;
  localparam int unsigned ENTRY_W  = OUT_DATA_WIDTH + KEEP_W + 1;

  typedef struct packed {
    logic [OUT_DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]         keep;
    logic                      last;
  } entry_t;

  logic [LANE_W-1:0]          lane_cnt_q, lane_cnt_d;
  logic [ELEM_W-1:0]          elem_cnt_q, elem_cnt_d;
  logic [OUT_DATA_WIDTH-1:0]  acc_q,      acc_d;

  logic [OUT_DATA_WIDTH-1:0]  w_word;
  logic [KEEP_W-1:0]          w_keep;
  logic                       w_accept;
  logic                       w_last_elem;
  logic                       w_last_lane;
  logic                       w_complete;
  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  entry_t                     w_wr_entry;
  entry_t                     w_rd_entry;

  // Readiness depends only on FIFO occupancy, never on the downstream ready.
  assign s_axis_tready = ~w_full;
  assign w_accept      = s_axis_tvalid & ~w_full;

  assign w_last_elem = (elem_cnt_q == ELEM_W'(FRAME_ELEMS - 1));
  assign w_last_lane = (lane_cnt_q == LANE_W'(LANES - 1));
  // A frame end closes the word early so frames never share a word.
  assign w_complete  = w_last_elem | w_last_lane;

  assign w_keep = KEEP_W'(keep_for(32'(lane_cnt_q), IN_BYTES, PACK, KEEP_W));

  // The accumulator only ever holds lanes below lane_cnt; higher lanes stay
  // zero, which provides the zero fill of short and zero-extended words.
  always_comb begin
    w_word = acc_q;
    w_word[32'(lane_cnt_q) * IN_DATA_WIDTH +: IN_DATA_WIDTH] = s_axis_tdata;
  end

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    elem_cnt_d = elem_cnt_q;
    acc_d      = acc_q;
    w_push     = 1'b0;
    if (w_accept) begin
      elem_cnt_d = w_last_elem ? '0 : elem_cnt_q + ELEM_W'(1);
      if (w_complete) begin
        w_push     = 1'b1;
        lane_cnt_d = '0;
        acc_d      = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
        acc_d      = w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      elem_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      elem_cnt_q <= elem_cnt_d;
      acc_q      <= acc_d;
    end
  end

  assign w_wr_entry.data = w_word;
  assign w_wr_entry.keep = w_keep;
  assign w_wr_entry.last = w_last_elem;

  axis_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_wr_entry),
    .pop_i   (m_axis_tready),
    .rdata_o (w_rd_entry),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level)
  );

  // Outputs come straight from the head entry, so they cannot change until
  // the head is popped.
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_rd_entry.data;
  assign m_axis_tkeep  = w_rd_entry.keep;
  assign m_axis_tlast  = w_rd_entry.last & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_axis_pack_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_pack_fifo
// Purpose  : Directed self-checking bench for axis_pack_fifo. Three instances:
//            default packing, zero-extend (PACK=0, 3 elements per frame) and
//            4 elements per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pack_fifo;

  localparam int FE = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default instance
  logic        s_valid, s_ready, m_valid, m_last, m_ready;
  logic [7:0]  s_data;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [4:0]  level;
  // PACK=0 instance
  logic        p0_s_valid, p0_s_ready, p0_m_valid, p0_m_last, p0_m_ready;
  logic [7:0]  p0_s_data;
  logic [31:0] p0_m_data;
  logic [3:0]  p0_m_keep;
  logic [4:0]  p0_level;
  // FRAME_ELEMS=4 instance
  logic        f4_s_valid, f4_s_ready, f4_m_valid, f4_m_last, f4_m_ready;
  logic [7:0]  f4_s_data;
  logic [31:0] f4_m_data;
  logic [3:0]  f4_m_keep;
  logic [4:0]  f4_level;

  axis_pack_fifo dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tready(s_ready),
    .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready), .level(level)
  );

  axis_pack_fifo #(.PACK(0), .FRAME_ELEMS(3)) dut_p0 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(p0_s_valid), .s_axis_tdata(p0_s_data), .s_axis_tready(p0_s_ready),
    .m_axis_tvalid(p0_m_valid), .m_axis_tdata(p0_m_data), .m_axis_tkeep(p0_m_keep),
    .m_axis_tlast(p0_m_last), .m_axis_tready(p0_m_ready), .level(p0_level)
  );

  axis_pack_fifo #(.FRAME_ELEMS(4)) dut_f4 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(f4_s_valid), .s_axis_tdata(f4_s_data), .s_axis_tready(f4_s_ready),
    .m_axis_tvalid(f4_m_valid), .m_axis_tdata(f4_m_data), .m_axis_tkeep(f4_m_keep),
    .m_axis_tlast(f4_m_last), .m_axis_tready(f4_m_ready), .level(f4_level)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_last[$];
  int next_elem;
  int ebase;
  int stall_err;

  function automatic logic [7:0] elem_val(input int i);
    return 8'((ebase + i) & 255);
  endfunction

  // Expected w-th word of a stream of whole FE-element frames, 4 lanes.
  task automatic exp_word(input int w, output logic [31:0] d,
                          output logic [3:0] k, output logic l);
    int wpf, f, s, first, n;
    wpf   = (FE + 3) / 4;
    f     = w / wpf;
    s     = w % wpf;
    first = f * FE + s * 4;
    n     = FE - s * 4;
    if (n > 4) n = 4;
    d = '0;
    k = '0;
    for (int j = 0; j < n; j++) begin
      d[j*8 +: 8] = elem_val(first + j);
      k[j]        = 1'b1;
    end
    l = (s == wpf - 1);
  endtask

  // Drives the default instance: inputs change on negedge, handshakes are
  // sampled 1 ns later and take effect on the following posedge.
  task automatic run_stream(input int total, input int vpct, input int rpct,
                            input int target, input int budget);
    logic        prev_stall;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    prev_stall = 1'b0;
    pd = '0; pk = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      s_valid = (next_elem < total) && ($urandom_range(99) < vpct);
      s_data  = elem_val(next_elem);
      m_ready = ($urandom_range(99) < rpct);
      #1;
      if (prev_stall) begin
        if (!(m_valid && m_data === pd && m_keep === pk && m_last === pl))
          stall_err++;
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pk = m_keep; pl = m_last;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_keep.push_back(m_keep);
        got_last.push_back(m_last);
      end
      if (s_valid && s_ready) next_elem++;
      if (next_elem >= total && got_data.size() >= target) break;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
    got_last.delete();
    next_elem = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1; s_data = 8'hEE;   // must be ignored
    m_ready = 1'b0;
    p0_s_valid = 1'b0; p0_s_data = '0; p0_m_ready = 1'b0;
    f4_s_valid = 1'b0; f4_s_data = '0; f4_m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", m_last); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_sready got=%b exp=1", s_ready); end
    checks++; if (p0_level !== 5'd0 || f4_level !== 5'd0) begin failures++; $display("FAIL rst_level_others got=%0d/%0d exp=0/0", p0_level, f4_level); end
  endtask

  task automatic test_pack_frame();
    logic [31:0] ed[3];
    logic [3:0]  ek[3];
    logic        el[3];
    ed[0] = 32'h04030201; ek[0] = 4'hF; el[0] = 1'b0;
    ed[1] = 32'h08070605; ek[1] = 4'hF; el[1] = 1'b0;
    ed[2] = 32'h00000A09; ek[2] = 4'h3; el[2] = 1'b1;
    clear_got();
    ebase = 1;
    run_stream(10, 100, 100, 3, 60);
    checks++;
    if (got_data.size() != 3) begin
      failures++; $display("FAIL pack_count got=%0d exp=3", got_data.size());
    end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ed[i] || got_keep[i] !== ek[i] || got_last[i] !== el[i]) begin
        failures++;
        $display("FAIL pack_word[%0d] got=%h/%h/%b exp=%h/%h/%b", i,
                 got_data[i], got_keep[i], got_last[i], ed[i], ek[i], el[i]);
      end
    end
    checks++; if (level !== 5'd0 || m_valid !== 1'b0) begin failures++; $display("FAIL pack_drained got level=%0d valid=%b exp 0/0", level, m_valid); end
  endtask

  task automatic check_model(input string tag, input int nwords);
    logic [31:0] d; logic [3:0] k; logic l;
    checks++;
    if (got_data.size() != nwords) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_data.size(), nwords);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      exp_word(i, d, k, l);
      checks++;
      if (got_data[i] !== d || got_keep[i] !== k || got_last[i] !== l) begin
        failures++;
        $display("FAIL %s_word[%0d] got=%h/%h/%b exp=%h/%h/%b", tag, i,
                 got_data[i], got_keep[i], got_last[i], d, k, l);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_got();
    ebase = 8'h40;
    stall_err = 0;
    run_stream(60, 100, 0, 0, 80);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_sready got=%b exp=0", s_ready); end
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL bp_level got=%0d exp=16", level); end
    checks++; if (next_elem != 54) begin failures++; $display("FAIL bp_accepted got=%0d exp=54", next_elem); end
    run_stream(60, 100, 100, 18, 300);
    check_model("bp", 18);
    checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_err); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL bp_drained got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    clear_got();
    ebase = 8'h30;
    stall_err = 0;
    run_stream(100 * FE, 50, 50, 300, 20000);
    check_model("rnd", 300);
    checks++; if (stall_err != 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0", stall_err); end
  endtask

  task automatic test_reset_midframe();
    clear_got();
    ebase = 8'h60;
    run_stream(6, 100, 0, 0, 20);
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL mid_pre_level got=%0d exp=1", level); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", level); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b exp=0", m_valid); end
    clear_got();
    ebase = 8'h11;
    run_stream(10, 100, 100, 3, 60);
    checks++;
    if (got_data.size() != 3) begin
      failures++; $display("FAIL mid_count got=%0d exp=3", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 32'h14131211 || got_keep[0] !== 4'hF || got_last[0] !== 1'b0) begin
        failures++; $display("FAIL mid_word0 got=%h/%h/%b exp=14131211/f/0", got_data[0], got_keep[0], got_last[0]);
      end
      checks++;
      if (got_data[1] !== 32'h18171615 || got_keep[1] !== 4'hF || got_last[1] !== 1'b0) begin
        failures++; $display("FAIL mid_word1 got=%h/%h/%b exp=18171615/f/0", got_data[1], got_keep[1], got_last[1]);
      end
      checks++;
      if (got_data[2] !== 32'h00001A19 || got_keep[2] !== 4'h3 || got_last[2] !== 1'b1) begin
        failures++; $display("FAIL mid_word2 got=%h/%h/%b exp=00001a19/3/1", got_data[2], got_keep[2], got_last[2]);
      end
    end
  endtask

  task automatic test_pack0();
    logic [7:0]  vin[3];
    logic [31:0] ed[3];
    logic        el[3];
    int idx, n;
    vin[0] = 8'hAA; vin[1] = 8'hBB; vin[2] = 8'hCC;
    ed[0] = 32'h000000AA; ed[1] = 32'h000000BB; ed[2] = 32'h000000CC;
    el[0] = 1'b0; el[1] = 1'b0; el[2] = 1'b1;
    idx = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      p0_s_valid = (idx < 3);
      p0_s_data  = vin[idx < 3 ? idx : 0];
      p0_m_ready = 1'b1;
      #1;
      if (p0_m_valid && p0_m_ready) begin
        checks++;
        if (n >= 3 || p0_m_data !== ed[n] || p0_m_keep !== 4'hF || p0_m_last !== el[n]) begin
          failures++;
          $display("FAIL p0_word[%0d] got=%h/%h/%b", n, p0_m_data, p0_m_keep, p0_m_last);
        end
        n++;
      end
      if (p0_s_valid && p0_s_ready) idx++;
      if (idx == 3 && n == 3) break;
    end
    @(negedge clk);
    p0_s_valid = 1'b0; p0_m_ready = 1'b0;
    checks++; if (n != 3) begin failures++; $display("FAIL p0_count got=%0d exp=3", n); end
  endtask

  task automatic test_frame4();
    logic [31:0] ed[2];
    int idx, n;
    ed[0] = 32'h24232221; ed[1] = 32'h28272625;
    idx = 0; n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      f4_s_valid = (idx < 8);
      f4_s_data  = 8'(8'h21 + idx);
      f4_m_ready = 1'b1;
      #1;
      if (f4_m_valid && f4_m_ready) begin
        checks++;
        if (n >= 2 || f4_m_data !== ed[n] || f4_m_keep !== 4'hF || f4_m_last !== 1'b1) begin
          failures++;
          $display("FAIL f4_word[%0d] got=%h/%h/%b", n, f4_m_data, f4_m_keep, f4_m_last);
        end
        n++;
      end
      if (f4_s_valid && f4_s_ready) idx++;
      if (idx == 8 && n == 2) break;
    end
    @(negedge clk);
    f4_s_valid = 1'b0; f4_m_ready = 1'b0;
    checks++; if (n != 2) begin failures++; $display("FAIL f4_count got=%0d exp=2", n); end
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    p0_s_valid = 1'b0; p0_s_data = '0; p0_m_ready = 1'b0;
    f4_s_valid = 1'b0; f4_s_data = '0; f4_m_ready = 1'b0;
    next_elem = 0; ebase = 0; stall_err = 0;
    test_reset();
    test_pack_frame();
    test_backpressure();
    test_random();
    test_reset_midframe();
    test_pack0();
    test_frame4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
